// File: rtl/jedro_1_alu_arbiter.sv
// Round-robin arbiter that time-shares one registered ALU between NUM_REQ requesters.
// Operands are latched at grant and held until the tagged result is accepted.
package jedro_1_defines;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_e;
endpackage

module jedro_1_alu_arbiter
    import jedro_1_defines::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                flush_i,
    input  logic [NUM_REQ-1:0]  req_valid_i,
    output logic [NUM_REQ-1:0]  req_ready_o,
    input  alu_op_e             req_sel_i  [NUM_REQ],
    input  logic [XLEN-1:0]     req_op_a_i [NUM_REQ],
    input  logic [XLEN-1:0]     req_op_b_i [NUM_REQ],
    output alu_op_e             alu_sel_o,
    output logic [XLEN-1:0]     alu_op_a_o,
    output logic [XLEN-1:0]     alu_op_b_o,
    input  logic [XLEN-1:0]     alu_res_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic [XLEN-1:0]     rsp_data_o,
    output logic                busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    alu_op_e         r_alu_sel;
    logic [XLEN-1:0] r_alu_op_a;
    logic [XLEN-1:0] r_alu_op_b;
    logic [ID_W-1:0] r_rsp_id;

    logic [1:0]      w_state_next;
    logic            w_window;
    logic            w_found;
    logic            w_grant;
    logic [ID_W-1:0] w_winner;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_rr_next;

    // A new operation may only be accepted when nothing is pending or the
    // pending result leaves this cycle; reset and flush close the window.
    assign w_window = rstn_i && !flush_i &&
                      ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready_i));

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant   = w_window && w_found;
    assign w_rr_next = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = w_grant && (w_winner == ID_W'(gi));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_RESP;
            ST_RESP:  if (rsp_ready_i) w_state_next = w_grant ? ST_ISSUE : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (flush_i) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_alu_sel  <= ALU_OP_ADD;
            r_alu_op_a <= '0;
            r_alu_op_b <= '0;
            r_rsp_id   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_alu_sel  <= req_sel_i[w_winner];
                r_alu_op_a <= req_op_a_i[w_winner];
                r_alu_op_b <= req_op_b_i[w_winner];
                r_rsp_id   <= w_winner;
                r_rr_ptr   <= w_rr_next;
            end
        end
    end

    assign alu_sel_o   = r_alu_sel;
    assign alu_op_a_o  = r_alu_op_a;
    assign alu_op_b_o  = r_alu_op_b;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_data_o  = alu_res_i;
    assign rsp_valid_o = (r_state == ST_RESP) && !flush_i;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jedro_1_alu_arbiter.sv
// Self-checking bench for jedro_1_alu_arbiter: directed scenarios plus a randomized
// run against a latency/round-robin reference model, with a registered ALU stand-in.
module tb_jedro_1_alu_arbiter;
    import jedro_1_defines::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                flush = 1'b0;
    logic [NUM_REQ-1:0]  req_valid = '0;
    logic [NUM_REQ-1:0]  req_ready;
    alu_op_e             req_sel [NUM_REQ];
    logic [XLEN-1:0]     req_a   [NUM_REQ];
    logic [XLEN-1:0]     req_b   [NUM_REQ];
    alu_op_e             alu_sel;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [XLEN-1:0]     alu_res;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [ID_W-1:0]     rsp_id;
    logic [XLEN-1:0]     rsp_data;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jedro_1_alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_sel_i   (req_sel),
        .req_op_a_i  (req_a),
        .req_op_b_i  (req_b),
        .alu_sel_o   (alu_sel),
        .alu_op_a_o  (alu_a),
        .alu_op_b_o  (alu_b),
        .alu_res_i   (alu_res),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    function automatic logic [XLEN-1:0] alu_ref(alu_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SLT:  return {31'b0, ($signed(a) < $signed(b))};
            ALU_OP_SLTU: return {31'b0, (a < b)};
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return $signed(a) >>> b[4:0];
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            default:     return '0;
        endcase
    endfunction

    // Stand-in for the shared ALU: result appears one clock after its inputs.
    always_ff @(posedge clk) alu_res <= alu_ref(alu_sel, alu_a, alu_b);

    task automatic drive_req(int i, alu_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        req_sel[i] = op;
        req_a[i]   = a;
        req_b[i]   = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0; flush = 1'b0; rsp_ready = 1'b1;
        rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    task automatic test_reset();
        drive_req(0, ALU_OP_SUB, 32'h11, 32'h22);
        drive_req(1, ALU_OP_XOR, 32'h33, 32'h44);
        req_valid = 2'b11;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready actual=%b required=00", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid actual=%b required=0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_cmp++; if (alu_sel !== ALU_OP_ADD) begin n_err++; $display("FAIL reset_alu_sel actual=%0d required=%0d", alu_sel, ALU_OP_ADD); end
        n_cmp++; if (alu_a !== '0 || alu_b !== '0) begin n_err++; $display("FAIL reset_operands actual=%h/%h required=0/0", alu_a, alu_b); end
        n_cmp++; if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id actual=%0d required=0", rsp_id); end
        req_valid = '0;
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_req(0, ALU_OP_ADD, 32'd5, 32'd7); req_valid = 2'b01; rsp_ready = 1'b1; #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready actual=%b required=01", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_issue actual=v%b/b%b required=v0/b1", rsp_valid, busy); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12) begin n_err++; $display("FAIL single_rsp actual=v%b id%0d d%0d required=v1 id0 d12", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_idle actual=b%b v%b required=b0 v0", busy, rsp_valid); end
        $display("single: id=0 data=%0d", 12);
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        drive_req(0, ALU_OP_SUB, 32'd10, 32'd3);
        drive_req(1, ALU_OP_XOR, 32'hF0, 32'h0F);
        req_valid = 2'b11; #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL contend_first actual=%b required=01", req_ready); end
        @(negedge clk); req_valid = 2'b10; #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL contend_issue_ready actual=%b required=00", req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd7) begin n_err++; $display("FAIL contend_rsp0 actual=v%b id%0d d%0d required=v1 id0 d7", rsp_valid, rsp_id, rsp_data); end
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL contend_b2b actual=%b required=10", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL contend_issue2 actual=v%b b%b required=v0 b1", rsp_valid, busy); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'hFF) begin n_err++; $display("FAIL contend_rsp1 actual=v%b id%0d d%h required=v1 id1 dff", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        $display("contention: id0=7 id1=0xff");
    endtask

    task automatic test_fairness();
        int exp_rr = 0;
        int cnt0 = 0;
        int cnt1 = 0;
        int grants = 0;
        logic [1:0] exp_ready;
        do_reset();
        drive_req(0, ALU_OP_ADD, 32'd1, 32'd1);
        drive_req(1, ALU_OP_ADD, 32'd2, 32'd2);
        // All 8 grants must land in 16 cycles: one operation every two cycles.
        for (int c = 0; c < 16 && grants < 8; c++) begin
            @(negedge clk); req_valid = 2'b11; rsp_ready = 1'b1; #1;
            if (req_ready !== 2'b00) begin
                exp_ready = 2'b01 << exp_rr;
                n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL fair_order grant=%0d actual=%b required=%b", grants, req_ready, exp_ready); end
                if (req_ready[0]) cnt0++;
                if (req_ready[1]) cnt1++;
                exp_rr = 1 - exp_rr;
                grants++;
            end
        end
        n_cmp++; if (grants !== 8) begin n_err++; $display("FAIL fair_grants actual=%0d required=8", grants); end
        n_cmp++; if (cnt0 !== 4 || cnt1 !== 4) begin n_err++; $display("FAIL fair_counts actual=%0d/%0d required=4/4", cnt0, cnt1); end
        @(negedge clk); req_valid = '0;
        repeat (3) @(negedge clk);
        $display("fairness: grants=%0d req0=%0d req1=%0d", grants, cnt0, cnt1);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive_req(0, ALU_OP_SLTU, 32'd1, 32'd2); req_valid = 2'b01; rsp_ready = 1'b0; #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_grant actual=%b required=01", req_ready); end
        @(negedge clk); req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_req(1, ALU_OP_ADD, 32'd9, 32'd9); req_valid = 2'b10; rsp_ready = 1'b0; #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_id !== 1'b0) begin n_err++; $display("FAIL bp_hold cyc=%0d actual=v%b d%0d id%0d required=v1 d1 id0", c, rsp_valid, rsp_data, rsp_id); end
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready cyc=%0d actual=%b required=00", c, req_ready); end
        end
        @(negedge clk); req_valid = '0; rsp_ready = 1'b1; #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin n_err++; $display("FAIL bp_accept actual=v%b d%0d required=v1 d1", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle actual=b%b v%b required=b0 v0", busy, rsp_valid); end
        $display("backpressure: id=0 data=1");
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_req(0, ALU_OP_SLL, 32'd1, 32'd4); req_valid = 2'b01; rsp_ready = 1'b1; #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL flush_grant actual=%b required=01", req_ready); end
        @(negedge clk); req_valid = 2'b10; flush = 1'b1; #1;
        n_cmp++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_issue actual=r%b v%b required=r00 v0", req_ready, rsp_valid); end
        @(negedge clk); req_valid = '0; flush = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle actual=b%b v%b required=b0 v0", busy, rsp_valid); end
        @(negedge clk);
        drive_req(1, ALU_OP_ADD, 32'd2, 32'd3); req_valid = 2'b10; #1;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin n_err++; $display("FAIL flush_next_grant actual=v%b r%b required=v0 r10", rsp_valid, req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd5) begin n_err++; $display("FAIL flush_next_rsp actual=v%b id%0d d%0d required=v1 id1 d5", rsp_valid, rsp_id, rsp_data); end
        // Flush in the response cycle must hide the result at once.
        flush = 1'b1; #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp_mask actual=%b required=0", rsp_valid); end
        @(negedge clk); flush = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_resp_idle actual=%b required=0", busy); end
        $display("flush: dropped SLL, completed id=1 data=5");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_req(0, ALU_OP_ADD, 32'd100, 32'd23); req_valid = 2'b01; rsp_ready = 1'b1; #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL areset_grant actual=%b required=01", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd123) begin n_err++; $display("FAIL areset_pre_rsp actual=v%b d%0d required=v1 d123", rsp_valid, rsp_data); end
        #1 rstn = 1'b0; #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL areset_drop actual=v%b b%b required=v0 b0", rsp_valid, busy); end
        n_cmp++; if (alu_a !== '0 || alu_b !== '0 || alu_sel !== ALU_OP_ADD) begin n_err++; $display("FAIL areset_alu actual=%h/%h/%0d required=0/0/0", alu_a, alu_b, alu_sel); end
        @(negedge clk); rstn = 1'b1;
        drive_req(1, ALU_OP_ADD, 32'd7, 32'd8); req_valid = 2'b11; #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL areset_rr actual=%b required=01", req_ready); end
        req_valid = 2'b10; #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL areset_req1 actual=%b required=10", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd15) begin n_err++; $display("FAIL areset_rsp actual=v%b id%0d d%0d required=v1 id1 d15", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        $display("async reset: post-reset id=1 data=15");
    endtask

    task automatic test_random();
        bit              m_inflight = 1'b0;
        int              m_age = 0;
        int              m_rr = 0;
        int              m_id = 0;
        logic [XLEN-1:0] m_data = '0;
        int              win;
        bit              window;
        bit              exp_valid;
        logic [1:0]      exp_ready;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 3) == 0)
                    drive_req(i, alu_op_e'($urandom_range(0, 9)), $urandom, $urandom);
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            // Result is due two cycles after its grant and waits there until taken.
            exp_valid = m_inflight && (m_age >= 2) && !flush;
            window    = !flush && (!m_inflight || ((m_age >= 2) && rsp_ready));
            win = -1;
            if (window)
                for (int k = 0; k < NUM_REQ; k++)
                    if (win < 0 && req_valid[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
            exp_ready = (win >= 0) ? (2'b01 << win) : 2'b00;
            n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready cyc=%0d actual=%b required=%b", c, req_ready, exp_ready); end
            n_cmp++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL rand_rsp_valid cyc=%0d actual=%b required=%b", c, rsp_valid, exp_valid); end
            n_cmp++; if (busy !== m_inflight) begin n_err++; $display("FAIL rand_busy cyc=%0d actual=%b required=%b", c, busy, m_inflight); end
            if (exp_valid) begin
                n_cmp++; if (rsp_id !== ID_W'(m_id) || rsp_data !== m_data) begin n_err++; $display("FAIL rand_rsp cyc=%0d actual=id%0d d%h required=id%0d d%h", c, rsp_id, rsp_data, m_id, m_data); end
                if (rsp_ready) $display("rand rsp: cyc=%0d id=%0d data=%h", c, m_id, m_data);
            end
            if (flush) m_inflight = 1'b0;
            else if (win >= 0) begin
                m_inflight = 1'b1; m_age = 1; m_id = win;
                m_data = alu_ref(req_sel[win], req_a[win], req_b[win]);
                m_rr = (win + 1) % NUM_REQ;
            end else if (m_inflight && m_age >= 2 && rsp_ready) m_inflight = 1'b0;
            else if (m_inflight && m_age < 2) m_age++;
        end
        @(negedge clk); req_valid = '0; flush = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_req(0, ALU_OP_ADD, '0, '0);
        drive_req(1, ALU_OP_ADD, '0, '0);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
